// File: rtl/butterfly_r2_pipe.sv
// Radix-2 FFT/IFFT butterfly, 3-stage valid/ready pipeline, saturating outputs.
// Define BFLY_ROUND_EN to round the twiddle product half toward +inf instead of flooring.
module butterfly_r2_pipe #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16,
  parameter int FRAC   = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     dif,
  input  logic                     inv,
  input  logic signed [DATA_W-1:0] a_r,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_r,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic signed [TW_W-1:0]   w_r,
  input  logic signed [TW_W-1:0]   w_i,
  output logic signed [DATA_W-1:0] x_r,
  output logic signed [DATA_W-1:0] x_i,
  output logic signed [DATA_W-1:0] y_r,
  output logic signed [DATA_W-1:0] y_i,
  output logic                     sat,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int SW = DATA_W + 1;
  localparam int WW = TW_W + 1;
  localparam int PW = DATA_W + TW_W + 3;
  localparam int XW = PW + 1;

  logic adv;

  logic                     v1, dif1;
  logic signed [DATA_W-1:0] a1_r, a1_i, b1_r, b1_i;
  logic signed [WW-1:0]     w1_r, w1_i;

  logic                     v2, dif2;
  logic signed [SW-1:0]     s2_r, s2_i;
  logic signed [DATA_W-1:0] a2_r, a2_i;
  logic signed [PW-1:0]     p2_r, p2_i;

  logic signed [SW-1:0] s_r, s_i, pr_r, pr_i;
  logic signed [PW-1:0] p_r, p_i;
  logic signed [PW-1:0] t_r, t_i;
  logic signed [XW-1:0] xw_r, xw_i, yw_r, yw_i;
  logic [DATA_W:0]      cx_r, cx_i, cy_r, cy_i;

  assign adv      = ~(out_valid & ~out_ready);
  assign in_ready = adv;

  always_comb begin
    s_r  = SW'(a1_r);
    s_i  = SW'(a1_i);
    pr_r = SW'(b1_r);
    pr_i = SW'(b1_i);
    if (dif1) begin
      s_r  = SW'(a1_r) + SW'(b1_r);
      s_i  = SW'(a1_i) + SW'(b1_i);
      pr_r = SW'(a1_r) - SW'(b1_r);
      pr_i = SW'(a1_i) - SW'(b1_i);
    end
    p_r = PW'(pr_r) * PW'(w1_r) - PW'(pr_i) * PW'(w1_i);
    p_i = PW'(pr_r) * PW'(w1_i) + PW'(pr_i) * PW'(w1_r);
  end

`ifdef BFLY_ROUND_EN
  localparam int RW = PW + 1;
  localparam logic signed [RW-1:0] HALF = RW'(2 ** (FRAC - 1));
  logic signed [RW-1:0] rr_r, rr_i;
  assign rr_r = RW'(p2_r) + HALF;
  assign rr_i = RW'(p2_i) + HALF;
  assign t_r  = PW'(rr_r >>> FRAC);
  assign t_i  = PW'(rr_i >>> FRAC);
`else
  assign t_r = p2_r >>> FRAC;
  assign t_i = p2_i >>> FRAC;
`endif

  always_comb begin
    xw_r = XW'(s2_r);
    xw_i = XW'(s2_i);
    yw_r = XW'(t_r);
    yw_i = XW'(t_i);
    if (!dif2) begin
      xw_r = XW'(a2_r) + XW'(t_r);
      xw_i = XW'(a2_i) + XW'(t_i);
      yw_r = XW'(a2_r) - XW'(t_r);
      yw_i = XW'(a2_i) - XW'(t_i);
    end
  end

  // Result is {clipped, value}; clip when the bits above the sign disagree.
  function automatic logic [DATA_W:0] clip(input logic signed [XW-1:0] v);
    logic [XW-DATA_W:0] hi;
    logic               of;
    hi = v[XW-1:DATA_W-1];
    of = ~((&hi) | ~(|hi));
    if (of) return {1'b1, v[XW-1], {(DATA_W-1){~v[XW-1]}}};
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  assign cx_r = clip(xw_r);
  assign cx_i = clip(xw_i);
  assign cy_r = clip(yw_r);
  assign cy_i = clip(yw_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      v1        <= 1'b0;
      dif1      <= 1'b0;
      a1_r      <= '0;
      a1_i      <= '0;
      b1_r      <= '0;
      b1_i      <= '0;
      w1_r      <= '0;
      w1_i      <= '0;
      v2        <= 1'b0;
      dif2      <= 1'b0;
      s2_r      <= '0;
      s2_i      <= '0;
      a2_r      <= '0;
      a2_i      <= '0;
      p2_r      <= '0;
      p2_i      <= '0;
      out_valid <= 1'b0;
      x_r       <= '0;
      x_i       <= '0;
      y_r       <= '0;
      y_i       <= '0;
      sat       <= 1'b0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        dif1 <= dif;
        a1_r <= a_r;
        a1_i <= a_i;
        b1_r <= b_r;
        b1_i <= b_i;
        w1_r <= WW'(w_r);
        w1_i <= inv ? -WW'(w_i) : WW'(w_i);
      end
      v2 <= v1;
      if (v1) begin
        dif2 <= dif1;
        s2_r <= s_r;
        s2_i <= s_i;
        a2_r <= a1_r;
        a2_i <= a1_i;
        p2_r <= p_r;
        p2_i <= p_i;
      end
      out_valid <= v2;
      if (v2) begin
        x_r <= cx_r[DATA_W-1:0];
        x_i <= cx_i[DATA_W-1:0];
        y_r <= cy_r[DATA_W-1:0];
        y_i <= cy_i[DATA_W-1:0];
        sat <= cx_r[DATA_W] | cx_i[DATA_W] | cy_r[DATA_W] | cy_i[DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_butterfly_r2_pipe.sv
// Bench for butterfly_r2_pipe: directed vectors plus randomized
// traffic scored against an integer reference model.
module tb_butterfly_r2_pipe;

  localparam int FRAC = 14;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, dif, inv, sat, out_valid, out_ready;
  logic signed [15:0] a_r, a_i, b_r, b_i, w_r, w_i;
  logic signed [15:0] x_r, x_i, y_r, y_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit dif, inv;
    int ar, ai, br, bi, wr, wi;
  } beat_t;

  typedef struct {
    int xr, xi, yr, yi;
    bit sat;
  } res_t;

  butterfly_r2_pipe #(.DATA_W(16), .TW_W(16), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .dif(dif), .inv(inv),
    .a_r(a_r), .a_i(a_i), .b_r(b_r), .b_i(b_i),
    .w_r(w_r), .w_i(w_i),
    .x_r(x_r), .x_i(x_i), .y_r(y_r), .y_i(y_i),
    .sat(sat), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic longint clampv(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Complex arithmetic straight from the butterfly definition.
  function automatic res_t model(beat_t b);
    longint wi, sr, si, pr, pi, qr, qi, tr, ti, xr, xi, yr, yi;
    res_t r;
    wi = b.inv ? -longint'(b.wi) : longint'(b.wi);
    if (b.dif) begin
      sr = b.ar + b.br; si = b.ai + b.bi;
      pr = b.ar - b.br; pi = b.ai - b.bi;
    end else begin
      sr = b.ar; si = b.ai;
      pr = b.br; pi = b.bi;
    end
    qr = pr * b.wr - pi * wi;
    qi = pr * wi + pi * b.wr;
`ifdef BFLY_ROUND_EN
    qr = qr + (longint'(1) << (FRAC - 1));
    qi = qi + (longint'(1) << (FRAC - 1));
`endif
    tr = qr >>> FRAC;
    ti = qi >>> FRAC;
    if (b.dif) begin
      xr = sr; xi = si; yr = tr; yi = ti;
    end else begin
      xr = b.ar + tr; xi = b.ai + ti;
      yr = b.ar - tr; yi = b.ai - ti;
    end
    r.xr = int'(clampv(xr));
    r.xi = int'(clampv(xi));
    r.yr = int'(clampv(yr));
    r.yi = int'(clampv(yi));
    r.sat = (clampv(xr) != xr) || (clampv(xi) != xi) ||
            (clampv(yr) != yr) || (clampv(yi) != yi);
    return r;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] t;
    int k;
    k = $urandom_range(7);
    if (k == 0) return -32768;
    if (k == 1) return 32767;
    t = 16'($urandom);
    return int'(t);
  endfunction

  function automatic beat_t rand_beat();
    beat_t b;
    b.dif = 1'($urandom);
    b.inv = 1'($urandom);
    b.ar = rnd16(); b.ai = rnd16();
    b.br = rnd16(); b.bi = rnd16();
    b.wr = rnd16(); b.wi = rnd16();
    return b;
  endfunction

  function automatic beat_t mk(bit d, bit i, int ar, int ai, int br,
                               int bi, int wr, int wi);
    beat_t b;
    b.dif = d; b.inv = i;
    b.ar = ar; b.ai = ai; b.br = br; b.bi = bi; b.wr = wr; b.wi = wi;
    return b;
  endfunction

  task automatic apply(beat_t b);
    dif = b.dif; inv = b.inv;
    a_r = 16'(b.ar); a_i = 16'(b.ai);
    b_r = 16'(b.br); b_i = 16'(b.bi);
    w_r = 16'(b.wr); w_i = 16'(b.wi);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic show(string name, res_t e);
    $display("FAIL %s: got v=%0b x=(%0d,%0d) y=(%0d,%0d) sat=%0b want x=(%0d,%0d) y=(%0d,%0d) sat=%0b",
             name, out_valid, x_r, x_i, y_r, y_i, sat,
             e.xr, e.xi, e.yr, e.yi, e.sat);
  endtask

  // Sends one beat, returns at the negedge three cycles after the transfer.
  task automatic one_beat(beat_t b, output bit early);
    apply(b);
    in_valid = 1'b1;
    out_ready = 1'b1;
    next();
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    early = out_valid;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid, sat, x_r, x_i, y_r, y_i, in_ready} !== {2'b00, 64'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state: v=%0b sat=%0b x=(%0d,%0d) y=(%0d,%0d) rdy=%0b want all 0, rdy=1",
               out_valid, sat, x_r, x_i, y_r, y_i, in_ready);
    end
    next();
    reset = 1'b0;
  endtask

  task automatic test_dif_basic();
    bit early;
    res_t e = '{1300, -100, 700, -300, 1'b0};
    one_beat(mk(1, 0, 1000, -200, 300, 100, 16384, 0), early);
    n_cmp++;
    if ({early, out_valid, x_r, x_i, y_r, y_i, sat} !==
        {1'b0, 1'b1, 16'(e.xr), 16'(e.xi), 16'(e.yr), 16'(e.yi), e.sat}) begin
      n_bad++;
      show("dif_basic", e);
    end
    next();
  endtask

  task automatic test_dit_modes();
    bit early;
    res_t e0 = '{1100, -500, 900, 100, 1'b0};
    res_t e1 = '{900, 100, 1100, -500, 1'b0};
    one_beat(mk(0, 0, 1000, -200, 300, 100, 0, -16384), early);
    n_cmp++;
    if ({early, out_valid, x_r, x_i, y_r, y_i, sat} !==
        {1'b0, 1'b1, 16'(e0.xr), 16'(e0.xi), 16'(e0.yr), 16'(e0.yi), e0.sat}) begin
      n_bad++;
      show("dit_fwd", e0);
    end
    next();
    one_beat(mk(0, 1, 1000, -200, 300, 100, 0, -16384), early);
    n_cmp++;
    if ({early, out_valid, x_r, x_i, y_r, y_i, sat} !==
        {1'b0, 1'b1, 16'(e1.xr), 16'(e1.xi), 16'(e1.yr), 16'(e1.yi), e1.sat}) begin
      n_bad++;
      show("dit_inv", e1);
    end
    next();
  endtask

  task automatic test_saturation();
    bit early;
    res_t e0 = '{32767, -32768, 0, 0, 1'b1};
    res_t e1 = '{1300, -100, 700, -300, 1'b0};
    one_beat(mk(1, 0, 32767, -32768, 32767, -32768, 16384, 0), early);
    n_cmp++;
    if ({out_valid, x_r, x_i, y_r, y_i, sat} !==
        {1'b1, 16'(e0.xr), 16'(e0.xi), 16'(e0.yr), 16'(e0.yi), e0.sat}) begin
      n_bad++;
      show("sat_clip", e0);
    end
    next();
    one_beat(mk(1, 0, 1000, -200, 300, 100, 16384, 0), early);
    n_cmp++;
    if ({out_valid, x_r, x_i, y_r, y_i, sat} !==
        {1'b1, 16'(e1.xr), 16'(e1.xi), 16'(e1.yr), 16'(e1.yi), e1.sat}) begin
      n_bad++;
      show("sat_clear", e1);
    end
    next();
  endtask

  task automatic test_rounding();
    bit early;
`ifdef BFLY_ROUND_EN
    int r_pos = 2, r_neg = -1;
`else
    int r_pos = 1, r_neg = -2;
`endif
    one_beat(mk(1, 0, 3, 0, 0, 0, 8192, 0), early);
    n_cmp++;
    if ({out_valid, y_r, sat} !== {1'b1, 16'(r_pos), 1'b0}) begin
      n_bad++;
      $display("FAIL round_pos: got y_r=%0d v=%0b want %0d", y_r, out_valid, r_pos);
    end
    next();
    one_beat(mk(1, 0, -3, 0, 0, 0, 8192, 0), early);
    n_cmp++;
    if ({out_valid, y_r, sat} !== {1'b1, 16'(r_neg), 1'b0}) begin
      n_bad++;
      $display("FAIL round_neg: got y_r=%0d v=%0b want %0d", y_r, out_valid, r_neg);
    end
    next();
  endtask

  task automatic test_back_to_back();
    beat_t bq[8];
    res_t q[$];
    res_t e;
    int sent = 0, got = 0, cyc = 0;
    bit stl = 0;
    logic [65:0] prev = '0;
    foreach (bq[i]) bq[i] = rand_beat();
    while (got < 8 && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      in_valid = (sent < 8);
      if (sent < 8) apply(bq[sent]);
      @(negedge clk);
      n_cmp++;
      if (in_ready !== !(out_valid && !out_ready)) begin
        n_bad++;
        $display("FAIL b2b_in_ready: got %0b at cycle %0d", in_ready, cyc);
      end
      if (stl) begin
        n_cmp++;
        if ({out_valid, x_r, x_i, y_r, y_i, sat} !== prev) begin
          n_bad++;
          $display("FAIL b2b_stall_stable: got %h want %h", {out_valid, x_r, x_i, y_r, y_i, sat}, prev);
        end
      end
      stl = out_valid && !out_ready;
      prev = {out_valid, x_r, x_i, y_r, y_i, sat};
      if (in_valid && in_ready) begin
        q.push_back(model(bq[sent]));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL b2b_extra: got unexpected beat x_r=%0d want none", x_r);
        end else begin
          e = q.pop_front();
          if ({x_r, x_i, y_r, y_i, sat} !==
              {16'(e.xr), 16'(e.xi), 16'(e.yr), 16'(e.yi), e.sat}) begin
            n_bad++;
            show("b2b_data", e);
          end
        end
        got++;
      end
      next();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != 8) begin
      n_bad++;
      $display("FAIL b2b_count: got %0d beats want 8", got);
    end
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL b2b_dup: got out_valid=%0b want 0", out_valid);
      end
      next();
    end
  endtask

  task automatic test_reset_midstream();
    bit early;
    res_t e;
    beat_t nb;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(rand_beat());
      in_valid = 1'b1;
      next();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    next();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, sat, x_r, x_i, y_r, y_i} !== 66'd0) begin
      n_bad++;
      $display("FAIL rst_mid_clear: got v=%0b sat=%0b x=(%0d,%0d) want 0",
               out_valid, sat, x_r, x_i);
    end
    next();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL rst_mid_flush: got out_valid=%0b at %0d want 0", out_valid, i);
      end
      next();
    end
    nb = rand_beat();
    e = model(nb);
    one_beat(nb, early);
    n_cmp++;
    if ({early, out_valid, x_r, x_i, y_r, y_i, sat} !==
        {1'b0, 1'b1, 16'(e.xr), 16'(e.xi), 16'(e.yr), 16'(e.yi), e.sat}) begin
      n_bad++;
      show("rst_mid_new", e);
    end
    next();
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e;
    beat_t cur = rand_beat();
    int sent = 0, got = 0, cyc = 0;
    while (got < 300 && cyc < 3000) begin
      in_valid = (sent < 300) && ($urandom_range(3) != 0);
      out_ready = ($urandom_range(9) < 7);
      apply(cur);
      @(negedge clk);
      if (in_valid && in_ready) begin
        q.push_back(model(cur));
        sent++;
        cur = rand_beat();
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_extra: got unexpected beat x_r=%0d want none", x_r);
        end else begin
          e = q.pop_front();
          if ({x_r, x_i, y_r, y_i, sat} !==
              {16'(e.xr), 16'(e.xi), 16'(e.yr), 16'(e.yi), e.sat}) begin
            n_bad++;
            show("rand_data", e);
          end
        end
        got++;
      end
      next();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_cmp++;
    if (got != 300) begin
      n_bad++;
      $display("FAIL rand_count: got %0d beats want 300", got);
    end
  endtask

  initial begin
    test_reset();
    test_dif_basic();
    test_dit_modes();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
